fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the execute stage.
- Generates sequential word addresses into a synchronous instruction memory and buffers the returned words with their PCs in a DEPTH-entry FIFO.
- Presents {ins, pc} to execute through a valid/ready handshake.
- On a control-flow change, execute drives redirect + redirect_pc; the queue flushes and refetches from the new PC.

---
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch with a DEPTH-entry {ins, pc} queue and redirect flush
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rstd,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             ins_valid,
    output logic [31:0]      ins,
    output logic [31:0]      pc,
    input  logic             ins_ready,
    output logic [PTR_W:0]   occupancy
);

    localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W + 2)'(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      ins_mem_q [DEPTH];
    logic [31:0]      pc_mem_q  [DEPTH];

    logic [PTR_W+1:0] level;
    logic             push;
    logic             pop;

    // In-flight requests reserve a slot so a returning word always has room.
    always_comb begin
        level    = {1'b0, count_q} + {{(PTR_W + 1){1'b0}}, inflight_q};
        imem_req = rstd & ~redirect & (level < DEPTH_L);
        push     = inflight_q & ~kill_q & ~redirect;
        pop      = ins_valid & ins_ready & ~redirect;
    end

    always_comb begin
        fpc_d      = fpc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = imem_req;
        kill_d     = kill_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (imem_req) begin
            resp_pc_d = fpc_q;
        end
        if (redirect) begin
            fpc_d    = redirect_pc;
            kill_d   = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                fpc_d = fpc_q + 32'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            fpc_q      <= '0;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]  <= resp_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            assert (!(push && !pop && count_q == DEPTH_C));
            assert (!(pop && count_q == '0));
        end
    end

    always_comb begin
        ins_valid = (count_q != '0);
        ins       = ins_valid ? ins_mem_q[rd_ptr_q] : 32'd0;
        pc        = ins_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
        imem_addr = fpc_q;
        occupancy = count_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue with a 1-cycle imem model
module tb_fetch_queue;

    logic        clk;
    logic        rstd;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ins_ready;
    logic [2:0]  occupancy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];

    fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ins_valid  (ins_valid),
        .ins        (ins),
        .pc         (pc),
        .ins_ready  (ins_ready),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr*0x11 one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem_addr * 32'h11 : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Consumption happens at the coming posedge; compare it against the scoreboard first.
    task automatic step();
        logic [31:0] e;
        if (rstd && ins_valid && ins_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra observed_pc=%h expected=none", pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_ins", ins, e * 32'h11);
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rstd        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ins_ready   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_occ", {29'd0, occupancy}, 32'd0);

        // Stream from reset
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        @(negedge clk);
        rstd = 1'b1;
        #1;
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        chk("c0_valid", {31'd0, ins_valid}, 32'd0);
        step();
        chk("c1_valid", {31'd0, ins_valid}, 32'd0);
        step();
        chk("c2_pc", pc, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", {31'd0, ins_valid}, 32'd1);
            step();
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure
        ins_ready = 1'b0;
        rstd      = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ins_valid}, 32'd0);
        @(negedge clk);
        rstd = 1'b1;
        #1;
        repeat (4) step();
        chk("bp_c4_occ", {29'd0, occupancy}, 32'd3);
        chk("bp_c4_req", {31'd0, imem_req}, 32'd0);
        repeat (6) step();
        chk("bp_full_occ", {29'd0, occupancy}, 32'd4);
        chk("bp_full_req", {31'd0, imem_req}, 32'd0);
        chk("bp_full_addr", imem_addr, 32'd4);
        chk("bp_full_pc", pc, 32'd0);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i));
        ins_ready = 1'b1;
        #1;
        chk("bp_pop_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("bp_rearm_req", {31'd0, imem_req}, 32'd1);
        chk("bp_rearm_addr", imem_addr, 32'd4);
        repeat (5) step();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        ins_ready = 1'b0;

        // Redirect while pc2 is in flight
        rstd = 1'b0;
        #1;
        @(negedge clk);
        rstd = 1'b1;
        #1;
        repeat (3) step();
        chk("rd_pre_occ", {29'd0, occupancy}, 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        ins_ready   = 1'b1;
        #1;
        chk("rd_cycle_req", {31'd0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("rd_next_occ", {29'd0, occupancy}, 32'd0);
        chk("rd_next_req", {31'd0, imem_req}, 32'd1);
        chk("rd_next_addr", imem_addr, 32'h40);
        chk("rd_next_valid", {31'd0, ins_valid}, 32'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + 32'(i));
        step();
        chk("rd_r2_valid", {31'd0, ins_valid}, 32'd0);
        step();
        chk("rd_r3_pc", pc, 32'h40);
        repeat (3) step();
        chk("rd_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_steady_valid", {31'd0, ins_valid}, 32'd1);

        // Redirect coinciding with a pop, into the address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        step();
        redirect = 1'b0;
        #1;
        chk("wr_w1_valid", {31'd0, ins_valid}, 32'd0);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        step();
        chk("wr_w2_valid", {31'd0, ins_valid}, 32'd0);
        step();
        chk("wr_w3_pc", pc, 32'hFFFF_FFFE);
        repeat (4) step();
        chk("wr_drained", 32'(exp_q.size()), 32'd0);
        ins_ready = 1'b0;
        #1;
        repeat (2) step();
        chk("mid_occ", {29'd0, occupancy}, 32'd3);

        // Reset mid-stream
        rstd = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("mid_rst_occ", {29'd0, occupancy}, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rstd      = 1'b1;
        ins_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
        #1;
        step();
        step();
        chk("mid_c2_pc", pc, 32'd0);
        repeat (3) step();
        ins_ready = 1'b0;
        chk("mid_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
